// File: rtl/spi_init_sequencer.sv
// spi_init_sequencer
//   Walks a configuration table held in an external synchronous ROM and turns
//   each entry into one register write on the 3-wire SPI master. A table entry
//   is either a write or a timed delay. Busy/done/error let the LCD bring-up
//   logic hold video off until the panel is configured.
//
//   Entry format: bit15=0 -> write {addr=[14:8], data=[7:0]}
//                 bit15=1 -> delay of [14:0]*DELAY_TICKS clocks (0 -> 1 clock)
//
//   Optional build macro SPI_SEQ_VERIFY_EN: every write is followed by a
//   readback of the same address. A data mismatch or a readback timeout
//   aborts the sequence with an error. When the macro is undefined the
//   readback port is tied off.
//
// Ports
//   i_clock, i_reset          clock, async active-high reset
//   i_start                   start request, sampled only while idle
//   o_busy, o_done, o_error   status; o_done is a 1-cycle pulse, o_error sticky
//   o_errIndex                table index of the failing entry
//   o_tblAddr / i_tblData     table ROM address / data (data 1 clock later)
//   o_txBegin .. i_txDone     write handshake to the SPI master
//   o_rxBegin .. i_rxDone     readback handshake (verify build only)
module spi_init_sequencer #(
  parameter int NUM_ENTRIES    = 32,
  parameter int IDX_W          = 5,
  parameter int DELAY_TICKS    = 1000,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [IDX_W-1:0] o_errIndex,
  output logic [IDX_W-1:0] o_tblAddr,
  input  logic [15:0]      i_tblData,
  output logic             o_txBegin,
  output logic [6:0]       o_txAddress,
  output logic [7:0]       o_txData,
  input  logic             i_txBusy,
  input  logic             i_txDone,
  output logic             o_rxBegin,
  output logic [6:0]       o_rxAddress,
  input  logic [7:0]       i_rxData,
  input  logic             i_rxDone
);

  localparam int DLY_W = $clog2(32768 * DELAY_TICKS);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_WRITE   = 4'd3,
    S_WAIT_TX = 4'd4,
    S_DELAY   = 4'd5,
    S_NEXT    = 4'd6,
    S_DONE    = 4'd7
`ifdef SPI_SEQ_VERIFY_EN
    , S_READ  = 4'd8,
    S_WAIT_RX = 4'd9
`endif
  } state_t;

  state_t           state_r, state_next_s;
  logic [IDX_W-1:0] idx_r;
  logic [DLY_W-1:0] dly_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             wait_state_s, timeout_s, start_ok_s, tx_go_s, fail_s;
  logic             busy_r, done_r, error_r, tx_begin_r;
  logic [IDX_W-1:0] err_idx_r;
  logic [6:0]       tx_addr_r;
  logic [7:0]       tx_data_r;
`ifdef SPI_SEQ_VERIFY_EN
  logic             rx_go_s, rx_begin_r;
  logic [6:0]       rx_addr_r;
`endif

  // Classify states in which the timeout counter runs.
  always_comb begin
    wait_state_s = 1'b0;
    case (state_r)
      S_WRITE, S_WAIT_TX: wait_state_s = 1'b1;
`ifdef SPI_SEQ_VERIFY_EN
      S_READ, S_WAIT_RX:  wait_state_s = 1'b1;
`endif
      default:            wait_state_s = 1'b0;
    endcase
  end

  assign timeout_s = wait_state_s && (tmo_cnt_r == TMO_MAX);

  // Next-state and handshake decisions.
  always_comb begin
    state_next_s = state_r;
    start_ok_s   = 1'b0;
    tx_go_s      = 1'b0;
    fail_s       = 1'b0;
`ifdef SPI_SEQ_VERIFY_EN
    rx_go_s      = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        if (i_start) begin
          start_ok_s   = 1'b1;
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_FETCH:  state_next_s = S_DECODE;
      S_DECODE: state_next_s = i_tblData[15] ? S_DELAY : S_WRITE;
      S_DELAY: begin
        if (dly_cnt_r <= DLY_W'(1)) state_next_s = S_NEXT;
        else                        state_next_s = S_DELAY;
      end
      S_WRITE: begin
        // A done pulse in this clock belongs to the previous transfer; hold off.
        if (timeout_s) begin
          fail_s       = 1'b1;
          state_next_s = S_DONE;
        end else if (!i_txBusy && !i_txDone) begin
          tx_go_s      = 1'b1;
          state_next_s = S_WAIT_TX;
        end else begin
          state_next_s = S_WRITE;
        end
      end
      S_WAIT_TX: begin
        if (i_txDone) begin
`ifdef SPI_SEQ_VERIFY_EN
          state_next_s = S_READ;
`else
          state_next_s = S_NEXT;
`endif
        end else if (timeout_s) begin
          fail_s       = 1'b1;
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_WAIT_TX;
        end
      end
`ifdef SPI_SEQ_VERIFY_EN
      S_READ: begin
        if (timeout_s) begin
          fail_s       = 1'b1;
          state_next_s = S_DONE;
        end else if (!i_txBusy && !i_txDone && !i_rxDone) begin
          rx_go_s      = 1'b1;
          state_next_s = S_WAIT_RX;
        end else begin
          state_next_s = S_READ;
        end
      end
      S_WAIT_RX: begin
        if (i_rxDone) begin
          if (i_rxData != tx_data_r) begin
            fail_s       = 1'b1;
            state_next_s = S_DONE;
          end else begin
            state_next_s = S_NEXT;
          end
        end else if (timeout_s) begin
          fail_s       = 1'b1;
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_WAIT_RX;
        end
      end
`endif
      S_NEXT:  state_next_s = (idx_r == LAST_IDX) ? S_DONE : S_FETCH;
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register and registered status/handshake outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_r    <= S_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      tx_begin_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      busy_r     <= (state_next_s != S_IDLE);
      done_r     <= (state_next_s == S_DONE);
      tx_begin_r <= tx_go_s;
    end
  end

  // Table index and sticky error capture.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      idx_r     <= '0;
      error_r   <= 1'b0;
      err_idx_r <= '0;
    end else if (start_ok_s) begin
      idx_r     <= '0;
      error_r   <= 1'b0;
      err_idx_r <= '0;
    end else begin
      if (fail_s) begin
        error_r   <= 1'b1;
        err_idx_r <= idx_r;
      end
      if (state_r == S_NEXT && idx_r != LAST_IDX) idx_r <= idx_r + IDX_W'(1);
    end
  end

  // Entry latch: write payload is held until the next write entry is decoded.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tx_addr_r <= 7'd0;
      tx_data_r <= 8'd0;
      dly_cnt_r <= '0;
    end else if (state_r == S_DECODE) begin
      if (i_tblData[15]) begin
        dly_cnt_r <= DLY_W'(i_tblData[14:0]) * DLY_W'(DELAY_TICKS);
      end else begin
        tx_addr_r <= i_tblData[14:8];
        tx_data_r <= i_tblData[7:0];
      end
    end else if (state_r == S_DELAY && dly_cnt_r != '0) begin
      dly_cnt_r <= dly_cnt_r - DLY_W'(1);
    end
  end

  // Timeout counter: restarts on every state change (so on every begin) and saturates.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tmo_cnt_r <= '0;
    end else if (!wait_state_s || state_next_s != state_r) begin
      tmo_cnt_r <= '0;
    end else if (tmo_cnt_r != TMO_MAX) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end

`ifdef SPI_SEQ_VERIFY_EN
  // Readback request register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_begin_r <= 1'b0;
      rx_addr_r  <= 7'd0;
    end else begin
      rx_begin_r <= rx_go_s;
      if (rx_go_s) rx_addr_r <= tx_addr_r;
    end
  end

  assign o_rxBegin   = rx_begin_r;
  assign o_rxAddress = rx_addr_r;
`else
  logic unused_rx;
  assign unused_rx   = ^{i_rxData, i_rxDone};
  assign o_rxBegin   = 1'b0;
  assign o_rxAddress = 7'd0;
`endif

  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_error     = error_r;
  assign o_errIndex  = err_idx_r;
  assign o_tblAddr   = idx_r;
  assign o_txBegin   = tx_begin_r;
  assign o_txAddress = tx_addr_r;
  assign o_txData    = tx_data_r;

endmodule

// File: tb/tb_spi_init_sequencer.sv
// Self-checking bench for spi_init_sequencer: table ROM and SPI master model,
// a vector table of scenarios, random tables, and hand-written corner cases.
module tb_spi_init_sequencer;
  localparam int NE  = 3;
  localparam int IW  = 2;
  localparam int DT  = 10;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, error;
  logic [IW-1:0] err_idx, tbl_addr;
  logic [15:0] tbl_data;
  logic tx_begin, tx_busy, tx_done;
  logic [6:0] tx_addr, rx_addr;
  logic [7:0] tx_data, rx_data;
  logic rx_begin, rx_done;

  always #5 clk = ~clk;

  spi_init_sequencer #(.NUM_ENTRIES(NE), .IDX_W(IW), .DELAY_TICKS(DT), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .o_busy(busy), .o_done(done), .o_error(error), .o_errIndex(err_idx),
    .o_tblAddr(tbl_addr), .i_tblData(tbl_data),
    .o_txBegin(tx_begin), .o_txAddress(tx_addr), .o_txData(tx_data),
    .i_txBusy(tx_busy), .i_txDone(tx_done),
    .o_rxBegin(rx_begin), .o_rxAddress(rx_addr), .i_rxData(rx_data), .i_rxDone(rx_done)
  );

  int total = 0;
  int bad = 0;

  // ---------------- table ROM (synchronous read) ----------------
  logic [15:0] rom [NE];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // ---------------- SPI master model ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int lat = 2;
  int hang_at = -1;
  int corrupt_at = -1;
  logic force_busy = 1'b0;
  logic m_busy, m_rd;
  int m_left, beg_n, rx_n;
  logic [7:0] mem [128];
  logic [14:0] beg_log[$];
  int beg_cyc[$];
  int done_cyc[$];

  assign tx_busy = m_busy | force_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_rd <= 1'b0; m_left <= 0; beg_n <= 0; rx_n <= 0;
      tx_done <= 1'b0; rx_done <= 1'b0; rx_data <= 8'h00;
    end else begin
      tx_done <= 1'b0;
      rx_done <= 1'b0;
      if (tx_begin) begin
        beg_log.push_back({tx_addr, tx_data});
        beg_cyc.push_back(cyc);
        mem[tx_addr] <= tx_data;
        m_rd   <= 1'b0;
        m_busy <= (beg_n != hang_at);
        m_left <= (beg_n == hang_at) ? -1 : lat;
        beg_n  <= beg_n + 1;
      end else if (rx_begin) begin
        rx_data <= mem[rx_addr] ^ ((rx_n == corrupt_at) ? 8'h01 : 8'h00);
        m_rd   <= 1'b1;
        m_busy <= 1'b1;
        m_left <= lat;
        rx_n   <= rx_n + 1;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          if (m_rd) rx_done <= 1'b1;
          else begin
            tx_done <= 1'b1;
            done_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  // ---------------- monitors ----------------
  int done_mon = 0;
  int txb_mon = 0;
  int rx_mon = 0;
  int over_mon = 0;
  always @(negedge clk) begin
    if (done) done_mon <= done_mon + 1;
    if (tx_begin) txb_mon <= txb_mon + 1;
    if (rx_begin || rx_addr != 7'd0) rx_mon <= rx_mon + 1;
    if (tbl_addr > IW'(NE - 1)) over_mon <= over_mon + 1;
  end

  // ---------------- reference model ----------------
  // Expected writes in order, and the delay total that must precede each one.
  logic [14:0] exp_w[$];
  int exp_gap[$];
  task automatic build_exp(input int stop_after);
    int acc;
    acc = 0;
    exp_w.delete();
    exp_gap.delete();
    for (int i = 0; i < NE; i++) begin
      if (rom[i][15]) acc += int'(rom[i][14:0]) * DT;
      else begin
        exp_w.push_back(rom[i][14:0]);
        exp_gap.push_back(acc);
        acc = 0;
      end
    end
    if (stop_after >= 0)
      while (exp_w.size() > stop_after + 1) exp_w.pop_back();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {1'b0, busy, done, error, err_idx, tbl_addr, tx_begin, tx_addr, tx_data, rx_begin, rx_addr};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    force_busy = 1'b0;
    beg_log.delete(); beg_cyc.delete(); done_cyc.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_and_wait(output int seen);
    int n;
    n = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    while (!done && n < 3000) begin @(negedge clk); n++; end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_wait: got no done within %0d clocks, want a done pulse", n);
    end
    seen = cyc;
    @(negedge clk);
    chk("done_width_busy_drop", {30'd0, done, busy}, 32'd0);
    @(negedge clk);
  endtask

  // Full run of one table with payload/order/gap/status checks.
  task automatic run_check(input logic [2:0][15:0] t, input int l, input int hang, input int corr,
                           input logic e_err, input logic [IW-1:0] e_idx);
    int d0, seen, stop;
    apply_reset();
    for (int i = 0; i < NE; i++) rom[i] = t[i];
    lat = l; hang_at = hang; corrupt_at = corr;
    stop = (hang >= 0) ? hang : corr;
    build_exp(stop);
    d0 = done_mon;
    start_and_wait(seen);
    chk("done_count", done_mon - d0, 32'd1);
    chk("error", {31'd0, error}, {31'd0, e_err});
    if (e_err) chk("err_index", {30'd0, err_idx}, {30'd0, e_idx});
    chk("begin_count", beg_log.size(), exp_w.size());
    for (int k = 0; k < exp_w.size() && k < beg_log.size(); k++) begin
      chk("begin_payload", {17'd0, beg_log[k]}, {17'd0, exp_w[k]});
      if (k > 0 && exp_gap[k] > 0 && done_cyc.size() >= k)
        chk("delay_gap", {31'd0, (beg_cyc[k] - done_cyc[k-1]) >= exp_gap[k]}, 32'd1);
    end
    if (hang >= 0 && beg_cyc.size() > 0)
      chk("timeout_latency", {31'd0, (seen - beg_cyc[beg_cyc.size()-1]) >= TMO &&
                                     (seen - beg_cyc[beg_cyc.size()-1]) <= TMO + 4}, 32'd1);
  endtask

  typedef struct {
    logic [2:0][15:0] t;
    int lat;
    int hang;
    int corr;
    logic e_err;
    logic [IW-1:0] e_idx;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [15:0] a, b, c, input int l, hang, corr,
                         input logic e_err, input logic [IW-1:0] e_idx);
    vec_t v;
    v.t[0] = a; v.t[1] = b; v.t[2] = c;
    v.lat = l; v.hang = hang; v.corr = corr; v.e_err = e_err; v.e_idx = e_idx;
    vecs.push_back(v);
  endtask

  initial begin
    int d0, n, b0, seen;
    logic [2:0][15:0] rt;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    add_vec(16'h0512, 16'h0634, 16'h07AB, 3, -1, -1, 1'b0, 2'd0);
    add_vec(16'h0512, 16'h8003, 16'h07AB, 2, -1, -1, 1'b0, 2'd0);
    add_vec(16'h0512, 16'h0634, 16'h07AB, 4,  2, -1, 1'b1, 2'd2);
    add_vec(16'h0512, 16'h0634, 16'h07AB, 1,  0, -1, 1'b1, 2'd0);
    add_vec(16'h8000, 16'h8000, 16'h0111, 5, -1, -1, 1'b0, 2'd0);
    add_vec(16'h8002, 16'h0A55, 16'h0B66, 1, -1, -1, 1'b0, 2'd0);
`ifdef SPI_SEQ_VERIFY_EN
    add_vec(16'h0512, 16'h0634, 16'h07AB, 2, -1,  1, 1'b1, 2'd1);
`endif
    foreach (vecs[v])
      run_check(vecs[v].t, vecs[v].lat, vecs[v].hang, vecs[v].corr, vecs[v].e_err, vecs[v].e_idx);

    // Random tables against the reference model
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NE; i++) begin
        if ($urandom_range(0, 3) == 0) rt[i] = 16'h8000 | 16'($urandom_range(0, 3));
        else rt[i] = {1'b0, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255))};
      end
      run_check(rt, $urandom_range(1, 6), -1, -1, 1'b0, 2'd0);
    end

    // Start while busy is ignored
    apply_reset();
    rom[0] = 16'h0512; rom[1] = 16'h0634; rom[2] = 16'h07AB;
    lat = 3; hang_at = -1; corrupt_at = -1;
    d0 = done_mon;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(tbl_addr == 2'd1 && busy) && n < 200) begin @(negedge clk); n++; end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    chk("restart_ignored_done", done_mon - d0, 32'd1);
    chk("restart_ignored_begins", beg_log.size(), 32'd3);
    chk("restart_ignored_idle", {31'd0, busy}, 32'd0);

    // Reset mid-sequence, then a clean restart from entry 0
    apply_reset();
    d0 = done_mon;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(tbl_addr == 2'd1 && busy) && n < 200) begin @(negedge clk); n++; end
    rst = 1'b1;
    #1;
    chk("midseq_reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    beg_log.delete(); beg_cyc.delete(); done_cyc.delete();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midseq_reset_no_done", done_mon - d0, 32'd0);
    start_and_wait(seen);
    chk("restart_begin_count", beg_log.size(), 32'd3);
    if (beg_log.size() > 0) chk("restart_first_entry", {17'd0, beg_log[0]}, 32'h0512);

    // Master busy held for 50 clocks before the first write
    apply_reset();
    lat = 20;
    force_busy = 1'b1;
    b0 = txb_mon;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (50) @(negedge clk);
    chk("busy_hold_no_begin", txb_mon - b0, 32'd0);
    force_busy = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_release_one_begin", txb_mon - b0, 32'd1);
    n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("busy_hold_total_begins", beg_log.size(), 32'd3);
    chk("busy_hold_error", {31'd0, error}, 32'd0);

`ifndef SPI_SEQ_VERIFY_EN
    chk("rx_port_tied_off", rx_mon, 32'd0);
`endif
    chk("index_in_range", over_mon, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
